// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: operation codes and
// burst-sequencer state encoding.
package univ_shift_reg_pkg;

   localparam logic [2:0] OP_HOLD = 3'd0;
   localparam logic [2:0] OP_LOAD = 3'd1;
   localparam logic [2:0] OP_SHL  = 3'd2;
   localparam logic [2:0] OP_SHR  = 3'd3;
   localparam logic [2:0] OP_ROL  = 3'd4;
   localparam logic [2:0] OP_ROR  = 3'd5;
   localparam logic [2:0] OP_ASR  = 3'd6;
   localparam logic [2:0] OP_CLR  = 3'd7;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Only the shift/rotate family may be repeated as a burst.
   function automatic logic is_burst_op(input logic [2:0] op);
      return (op >= OP_SHL) && (op <= OP_ASR);
   endfunction

endpackage

// File: rtl/univ_shift_reg_shift_step_comb.sv
// Next-value function of the shift register; shared by manual and burst paths
// so every operation is defined in exactly one place.
module shift_step_comb
   import univ_shift_reg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LANE  = 1
) (
   input  logic [WIDTH-1:0] cur_i,
   input  logic [2:0]       op_i,
   input  logic [LANE-1:0]  din_i,
   input  logic [WIDTH-1:0] pin_i,
   output logic [WIDTH-1:0] nxt_o
);

   always_comb begin
      nxt_o = cur_i;
      case (op_i)
         OP_LOAD: nxt_o = pin_i;
         OP_SHL:  nxt_o = {cur_i[WIDTH-LANE-1:0], din_i};
         OP_SHR:  nxt_o = {din_i, cur_i[WIDTH-1:LANE]};
         OP_ROL:  nxt_o = {cur_i[WIDTH-LANE-1:0], cur_i[WIDTH-1 -: LANE]};
         OP_ROR:  nxt_o = {cur_i[LANE-1:0], cur_i[WIDTH-1:LANE]};
         OP_ASR:  nxt_o = {{LANE{cur_i[WIDTH-1]}}, cur_i[WIDTH-1:LANE]};
         OP_CLR:  nxt_o = '0;
         default: nxt_o = cur_i;
      endcase
   end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: manual load/shift/rotate operations plus an
// auto-burst sequencer that repeats one shift op a programmed number of times.
module univ_shift_reg
   import univ_shift_reg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LANE  = 1,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en_i,
   input  logic [2:0]       op_i,
   input  logic [LANE-1:0]  din_i,
   input  logic [WIDTH-1:0] pin_i,
   input  logic             start_i,
   input  logic [CNT_W-1:0] burst_len_i,
   output logic [WIDTH-1:0] out_o,
   output logic [LANE-1:0]  sout_msb_o,
   output logic [LANE-1:0]  sout_lsb_o,
   output logic             busy_o,
   output logic             done_o
);

   state_e           state_q;
   logic [2:0]       op_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] out_d;
   logic             busy_q;
   logic             done_q;
   logic [2:0]       step_op;

   // While a burst runs the latched op drives the datapath; op_i is ignored.
   assign step_op = (state_q == RUN) ? op_q : op_i;

   shift_step_comb #(
      .WIDTH (WIDTH),
      .LANE  (LANE)
   ) u_step (
      .cur_i (out_q),
      .op_i  (step_op),
      .din_i (din_i),
      .pin_i (pin_i),
      .nxt_o (out_d)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         out_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  // Acceptance edge never shifts; degenerate requests just report done.
                  if (is_burst_op(op_i) && (burst_len_i != '0)) begin
                     op_q    <= op_i;
                     cnt_q   <= burst_len_i;
                     state_q <= RUN;
                     busy_q  <= 1'b1;
                  end else begin
                     done_q <= 1'b1;
                  end
               end else if (en_i) begin
                  out_q <= out_d;
               end
            end
            RUN: begin
               if (en_i) begin
                  out_q <= out_d;
                  cnt_q <= cnt_q - 1'b1;
                  if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_o      = out_q;
   assign sout_msb_o = out_q[WIDTH-1 -: LANE];
   assign sout_lsb_o = out_q[LANE-1:0];
   assign busy_o     = busy_q;
   assign done_o     = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: LANE=1 and LANE=2 instances, hand-computed
// expectations checked with immediate assertions.
module tb_univ_shift_reg;

   logic clk = 1'b0;
   logic rstn;

   logic       en, start, din;
   logic [2:0] op;
   logic [7:0] pin;
   logic [3:0] blen;
   logic [7:0] out;
   logic       smsb, slsb, busy, done;

   logic       en2, start2;
   logic [1:0] din2;
   logic [2:0] op2;
   logic [7:0] pin2;
   logic [3:0] blen2;
   logic [7:0] out2;
   logic [1:0] smsb2, slsb2;
   logic       busy2, done2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   univ_shift_reg #(.WIDTH(8), .LANE(1), .CNT_W(4)) u8 (
      .clk(clk), .rstn(rstn), .en_i(en), .op_i(op), .din_i(din), .pin_i(pin),
      .start_i(start), .burst_len_i(blen), .out_o(out), .sout_msb_o(smsb),
      .sout_lsb_o(slsb), .busy_o(busy), .done_o(done)
   );

   univ_shift_reg #(.WIDTH(8), .LANE(2), .CNT_W(4)) u2 (
      .clk(clk), .rstn(rstn), .en_i(en2), .op_i(op2), .din_i(din2), .pin_i(pin2),
      .start_i(start2), .burst_len_i(blen2), .out_o(out2), .sout_msb_o(smsb2),
      .sout_lsb_o(slsb2), .busy_o(busy2), .done_o(done2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      assert (got === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [7:0] t3_exp [7] = '{8'h78, 8'h78, 8'h3C, 8'h3C, 8'h1E, 8'h1E, 8'h0F};
   logic [7:0] t6_exp [4] = '{8'hB4, 8'h2D, 8'h4B, 8'hD2};

   initial begin
      rstn = 1'b0; en = 1'b0; start = 1'b0; din = 1'b0; op = 3'd0; pin = '0; blen = '0;
      en2 = 1'b0; start2 = 1'b0; din2 = '0; op2 = 3'd0; pin2 = '0; blen2 = '0;
      tick(); tick();
      check("rst_out", out, 8'h00);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_out2", out2, 8'h00);
      rstn = 1'b1;

      // Manual operations
      en = 1'b1; op = 3'd1; pin = 8'hA5; tick();
      check("load", out, 8'hA5);
      check("load_msb", smsb, 1);
      check("load_lsb", slsb, 1);
      op = 3'd4; tick();
      check("rol", out, 8'h4B);
      en = 1'b0; tick();
      check("en0_hold", out, 8'h4B);
      en = 1'b1; op = 3'd1; pin = 8'h80; tick();
      op = 3'd6; tick();
      check("asr", out, 8'hC0);
      op = 3'd3; din = 1'b1; tick();
      check("shr_din1", out, 8'hE0);
      op = 3'd2; din = 1'b0; tick();
      check("shl_din0", out, 8'hC0);
      op = 3'd5; tick();
      check("ror", out, 8'h60);
      op = 3'd0; tick();
      check("hold", out, 8'h60);
      op = 3'd7; tick();
      check("clr", out, 8'h00);

      // Burst SHL N=8, din=1
      op = 3'd1; pin = 8'h00; tick();
      op = 3'd2; din = 1'b1; blen = 4'd8; start = 1'b1; tick();
      check("b8_accept_out", out, 8'h00);
      check("b8_accept_busy", busy, 1);
      start = 1'b0; op = 3'd0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         check("b8_busy", busy, (i < 8));
         check("b8_done", done, (i == 8));
      end
      check("b8_out", out, 8'hFF);
      check("b8_msb", smsb, 1);
      tick();
      check("b8_done_clear", done, 0);
      check("b8_idle_hold", out, 8'hFF);

      // Burst SHR N=4 with en toggling
      en = 1'b1; op = 3'd1; pin = 8'hF0; din = 1'b0; tick();
      op = 3'd3; blen = 4'd4; start = 1'b1; tick();
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         en = (i % 2 == 0);
         tick();
         check("b4_out", out, t3_exp[i]);
         check("b4_busy", busy, (i < 6));
      end
      check("b4_done", done, 1);
      en = 1'b1; op = 3'd0; tick();
      check("b4_done_clear", done, 0);

      // start with N=0: no burst, only done
      op = 3'd2; blen = 4'd0; start = 1'b1; tick();
      check("n0_out", out, 8'h0F);
      check("n0_busy", busy, 0);
      check("n0_done", done, 1);
      start = 1'b0; op = 3'd0; tick();
      check("n0_done_clear", done, 0);
      check("n0_busy_after", busy, 0);

      // Reset in the middle of a 6-step burst
      op = 3'd1; pin = 8'h01; tick();
      op = 3'd2; din = 1'b0; blen = 4'd6; start = 1'b1; tick();
      start = 1'b0;
      tick(); tick(); tick();
      check("mid_out", out, 8'h08);
      check("mid_busy", busy, 1);
      rstn = 1'b0; tick();
      check("abort_out", out, 8'h00);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      rstn = 1'b1; op = 3'd0; tick();
      check("abort_no_done", done, 0);
      op = 3'd1; pin = 8'h81; tick();
      check("post_rst_load", out, 8'h81);
      op = 3'd4; blen = 4'd2; start = 1'b1; tick();
      start = 1'b0; tick(); tick();
      check("post_rst_burst", out, 8'h06);
      check("post_rst_done", done, 1);

      // Maximum burst length: 15 rotates left == one rotate right
      op = 3'd1; pin = 8'h81; tick();
      op = 3'd4; blen = 4'd15; start = 1'b1; tick();
      start = 1'b0; op = 3'd0;
      for (int i = 0; i < 14; i++) tick();
      check("max_busy", busy, 1);
      tick();
      check("max_out", out, 8'hC0);
      check("max_done", done, 1);
      check("max_busy_end", busy, 0);

      // LANE=2 ROR burst, op/start changes during RUN ignored
      en2 = 1'b1; op2 = 3'd1; pin2 = 8'hD2; tick();
      check("l2_load", out2, 8'hD2);
      check("l2_lsb", slsb2, 2'b10);
      check("l2_msb", smsb2, 2'b11);
      op2 = 3'd5; blen2 = 4'd4; start2 = 1'b1; tick();
      check("l2_accept", out2, 8'hD2);
      check("l2_busy", busy2, 1);
      op2 = 3'd7; pin2 = 8'h00;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("l2_ror", out2, t6_exp[i]);
      end
      check("l2_done", done2, 1);
      check("l2_busy_end", busy2, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register: WIDTH-bit register shifted LANE bits per step.
- Supports parallel load, logical, rotate and arithmetic shifts in both directions.
- Auto-burst mode runs one operation a programmed number of times, tracked with busy/done flags.
- Used as the common serialiser/deserialiser and shift datapath for serial peripherals and arithmetic units.

Parameters:
- WIDTH, 8, register width in bits; must be a multiple of LANE and >= 2*LANE.
- LANE, 1, bits inserted/removed per shift step.
- CNT_W, 4, width of burst_len and of the internal step counter.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  synchronous active-low reset.
- en  in  1  step enable; low stalls manual ops and burst steps.
- op  in  3  operation select (encoding in Behaviour).
- din  in  LANE  serial lane inserted by SHL/SHR.
- pin  in  WIDTH  parallel load data.
- start  in  1  begin burst using op and burst_len.
- burst_len  in  CNT_W  number of burst steps N.
- out  out  WIDTH  register contents.
- sout_msb  out  LANE  out[WIDTH-1 -: LANE], combinational from register.
- sout_lsb  out  LANE  out[LANE-1:0], combinational from register.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse on burst completion.

Behaviour:
- Reset: reset rstn, synchronous, active-low; clock clk. out=0, busy=0, done=0, FSM=IDLE, counter=0. Reset has priority over everything, including mid-burst (burst aborted, no done pulse).
- op encoding:
  - 0 HOLD.
  - 1 LOAD: out<=pin.
  - 2 SHL: out<={out[WIDTH-LANE-1:0],din}.
  - 3 SHR: out<={din,out[WIDTH-1:LANE]}.
  - 4 ROL by LANE.
  - 5 ROR by LANE.
  - 6 ASR: LANE copies of out[WIDTH-1] enter at MSB.
  - 7 CLR: out<=0.
- Manual mode (FSM=IDLE, start=0):
  - At an edge with en=1, apply op.
  - en=0 holds out.
  - Latency is 1 clock.
- FSM states: IDLE, RUN.
- IDLE with start=1:
  - Accepted regardless of en. No shift occurs on the accepting edge; manual op is suppressed that cycle.
  - If op in {2..6} and N>0: latch op into op_q, counter<=N, FSM->RUN, busy=1 from the next cycle.
  - If N=0 or op not in {2..6}: out unchanged, FSM stays IDLE, busy stays 0, done=1 for the next cycle.
- RUN:
  - Each edge with en=1 applies op_q once, samples current din, and decrements the counter.
  - en=0 stalls: no shift, counter held.
  - The step made with counter==1 returns FSM->IDLE, sets busy=0 and pulses done=1 for exactly the following cycle.
  - Total: N shifts over N enabled cycles after acceptance.
- In RUN, start, op and pin are ignored; op changes do not affect op_q.
- done is registered, high exactly one cycle, never simultaneously with busy=1.
- A new start is accepted in the same cycle done is high, since FSM is IDLE.
- N=2^CNT_W-1 is legal; counter never wraps below 0.
- All arithmetic is unsigned on the counter; no flags beyond busy/done.

Decomposition:
- Shared package shift_pkg: op encoding constants (OP_HOLD..OP_CLR), FSM state typedef (IDLE, RUN).
- Natural sub-module: shift_step_comb. Purely combinational next-value function (out, op, din, pin) -> next out. Used by both the manual and burst paths so that operation semantics are defined once.
- Top holds register, FSM, counter, done pulse.

Test Plan:
1. WIDTH=8, LANE=1: reset, LOAD pin=8'hA5 with en=1, then ROL once -> out=8'h4B; ASR on 8'h80 -> 8'hC0.
2. WIDTH=8, LANE=1: LOAD 8'h00, start SHL N=8 with din=1 every step, en=1 continuously:
   - busy high for 8 cycles.
   - out=8'hFF after the 8th step edge.
   - done high exactly the next cycle.
   - sout_msb=1 at end.
3. Burst SHR N=4 on 8'hF0 with en toggled 1,0,1,0,...:
   - 4 shifts over 7 cycles.
   - Counter and out held on en=0 cycles.
   - Final out=8'h0F with din=0.
4. start with N=0, op=SHL:
   - out unchanged.
   - busy never asserted.
   - done=1 the following cycle only.
5. rstn=0 asserted mid-burst (after 3 of 6 steps):
   - Next cycle out=0, busy=0, done=0, FSM=IDLE.
   - Later start works normally.
6. WIDTH=8, LANE=2: LOAD 8'b11_01_00_10, burst ROR N=4 -> out returns to 8'b11010010. start/op changes during RUN are ignored.
